// File: rtl/pc_fetch_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : pc_fetch_ctrl_if
//  Description : Bundle of PC, instruction-memory, decode and redirect signals
//                that connect the fetch sequencer to its surroundings.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pc_fetch_ctrl_if;
    logic [31:0] pc_cur;
    logic [31:0] next_pc;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        trap;
    logic        misalign_err;

    // Fetch sequencer side
    modport master (
        input  pc_cur, imem_req_ready, imem_rsp_valid, imem_rsp_data,
               inst_ready, redirect_valid, redirect_pc, trap,
        output next_pc, imem_req_valid, imem_req_addr,
               inst_valid, inst_data, inst_pc, misalign_err
    );

    // PC register / memory / decode side
    modport slave (
        output pc_cur, imem_req_ready, imem_rsp_valid, imem_rsp_data,
               inst_ready, redirect_valid, redirect_pc, trap,
        input  next_pc, imem_req_valid, imem_req_addr,
               inst_valid, inst_data, inst_pc, misalign_err
    );
endinterface
`default_nettype wire

// File: rtl/pc_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pc_fetch_ctrl
//  Description : Non-pipelined fetch sequencer. Computes NextPC for the PC
//                register, issues one instruction-memory request at a time,
//                buffers the returned word for decode and applies
//                redirect / trap flushes.
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
    input  wire logic          clk,
    input  wire logic          rst,
    pc_fetch_ctrl_if.master    bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_OUT   = 3'd3,
        S_FLUSH = 3'd4
    } state_t;

    state_t      r_state;
    logic [31:0] r_req_pc;
    logic        r_inst_valid;
    logic [31:0] r_inst_data;
    logic [31:0] r_inst_pc;
    logic        r_misalign_err;

    logic        w_in_req;
    logic        w_req_fire;
    logic        w_flush;
    logic        w_mis_tgt;
    logic [31:0] w_next_pc;

    assign w_in_req   = (r_state == S_REQ) && !rst;
    assign w_req_fire = w_in_req && bus.imem_req_ready;
    assign w_flush    = bus.trap || bus.redirect_valid;
    assign w_mis_tgt  = bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);

    // NextPC selection: reset, trap, misaligned redirect, redirect, advance, hold
    always_comb begin
        w_next_pc = bus.pc_cur;
        if (rst) begin
            w_next_pc = RESET_PC;
        end else if (bus.trap || w_mis_tgt) begin
            w_next_pc = TRAP_VEC;
        end else if (bus.redirect_valid) begin
            w_next_pc = bus.redirect_pc;
        end else if (w_req_fire) begin
            w_next_pc = bus.pc_cur + 32'd4;
        end
    end

    assign bus.next_pc        = w_next_pc;
    assign bus.imem_req_valid = w_in_req;
    assign bus.imem_req_addr  = bus.pc_cur;
    assign bus.inst_valid     = r_inst_valid;
    assign bus.inst_data      = r_inst_data;
    assign bus.inst_pc        = r_inst_pc;
    assign bus.misalign_err   = r_misalign_err;

    // Fetch sequencer: request, wait for the word, hand it to decode, flush
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_req_pc       <= 32'h0;
            r_inst_valid   <= 1'b0;
            r_inst_data    <= 32'h0;
            r_inst_pc      <= 32'h0;
            r_misalign_err <= 1'b0;
        end else begin
            // A trap wins over the redirect, so no misalign report then
            r_misalign_err <= w_mis_tgt && !bus.trap;

            case (r_state)
                S_IDLE: begin
                    r_state <= S_REQ;
                end
                S_REQ: begin
                    if (bus.imem_req_ready) begin
                        r_req_pc <= bus.pc_cur;
                        // An accepted request still owes a response; a flush
                        // in the same cycle means that response must be dropped
                        r_state  <= w_flush ? S_FLUSH : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (w_flush) begin
                        r_state <= bus.imem_rsp_valid ? S_REQ : S_FLUSH;
                    end else if (bus.imem_rsp_valid) begin
                        r_inst_data  <= bus.imem_rsp_data;
                        r_inst_pc    <= r_req_pc;
                        r_inst_valid <= 1'b1;
                        r_state      <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (w_flush || bus.inst_ready) begin
                        r_inst_valid <= 1'b0;
                        r_state      <= S_REQ;
                    end
                end
                S_FLUSH: begin
                    // The single outstanding response retires the flush; a
                    // further flush only changes NextPC, which is already applied
                    if (bus.imem_rsp_valid) begin
                        r_state <= S_REQ;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            if (w_flush) begin
                r_inst_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_fetch_ctrl
//  Description : Self-checking bench for pc_fetch_ctrl with a transaction
//                level reference model and directed stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_fetch_ctrl;

    localparam logic [31:0] C_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] C_TRAP_VEC = 32'h0000_0100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pc_fetch_ctrl_if bus ();

    pc_fetch_ctrl #(
        .RESET_PC (C_RESET_PC),
        .TRAP_VEC (C_TRAP_VEC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // PC register in front of the sequencer
    logic [31:0] r_pc = 32'h0;
    always @(posedge clk) r_pc <= bus.next_pc;
    assign bus.pc_cur = r_pc;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    // m_owed : one memory response is still owed to us
    // m_stale: that owed response belongs to a flushed fetch
    // m_bv   : decode buffer holds a word
    bit          m_ok    = 1'b0;
    bit          m_idle  = 1'b1;
    bit          m_owed  = 1'b0;
    bit          m_stale = 1'b0;
    bit          m_bv    = 1'b0;
    bit          m_mis   = 1'b0;
    logic [31:0] m_bd    = 32'h0;
    logic [31:0] m_bpc   = 32'h0;
    logic [31:0] m_rpc   = 32'h0;
    bit          m_fl, m_fire, m_taken;

    // A new request is offered only when nothing is owed, nothing buffered
    function automatic logic f_req_valid();
        return !rst && !m_idle && !m_owed && !m_bv;
    endfunction

    function automatic logic [31:0] f_next_pc();
        if (rst)                                              return C_RESET_PC;
        if (bus.trap)                                         return C_TRAP_VEC;
        if (bus.redirect_valid && bus.redirect_pc[1:0] != 2'b00) return C_TRAP_VEC;
        if (bus.redirect_valid)                               return bus.redirect_pc;
        if (f_req_valid() && bus.imem_req_ready)              return r_pc + 32'd4;
        return r_pc;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_ok = 1'b1; m_idle = 1'b1; m_owed = 1'b0; m_stale = 1'b0;
            m_bv = 1'b0; m_bd = 32'h0; m_bpc = 32'h0; m_rpc = 32'h0; m_mis = 1'b0;
        end else begin
            m_fl    = bus.trap || bus.redirect_valid;
            m_fire  = f_req_valid() && bus.imem_req_ready;
            m_taken = m_owed && bus.imem_rsp_valid;
            m_mis   = bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00) && !bus.trap;
            if (m_fl || (m_bv && bus.inst_ready)) m_bv = 1'b0;
            if (m_taken && !m_stale && !m_fl) begin
                m_bv  = 1'b1;
                m_bd  = bus.imem_rsp_data;
                m_bpc = m_rpc;
            end
            if (m_fire) begin
                m_owed = 1'b1; m_stale = m_fl; m_rpc = r_pc;
            end else if (m_taken) begin
                m_owed = 1'b0; m_stale = 1'b0;
            end else if (m_owed && m_fl) begin
                m_stale = 1'b1;
            end
            m_idle = 1'b0;
        end
    end

    // Every-cycle comparison, late in the low clock phase
    always begin
        @(negedge clk);
        #4;
        if (m_ok) begin
            chk32("next_pc",        bus.next_pc,        f_next_pc());
            chk1 ("imem_req_valid", bus.imem_req_valid, f_req_valid());
            if (f_req_valid()) chk32("imem_req_addr", bus.imem_req_addr, r_pc);
            chk1 ("inst_valid",     bus.inst_valid,     m_bv);
            chk32("inst_data",      bus.inst_data,      m_bd);
            chk32("inst_pc",        bus.inst_pc,        m_bpc);
            chk1 ("misalign_err",   bus.misalign_err,   m_mis);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc();
        @(negedge clk);
        bus.imem_rsp_valid = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.trap           = 1'b0;
    endtask

    initial begin
        bus.imem_req_ready = 1'b1;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;
        bus.inst_ready     = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.trap           = 1'b0;

        cyc(); cyc();
        #2;
        chk32("rst_next_pc",    bus.next_pc, 32'h0);
        chk1 ("rst_req_valid",  bus.imem_req_valid, 1'b0);
        chk1 ("rst_inst_valid", bus.inst_valid, 1'b0);

        // Basic fetch
        cyc(); rst = 1'b0;
        #2 chk1("idle_req_valid", bus.imem_req_valid, 1'b0);
        cyc();
        #2;
        chk1 ("t1_req_valid", bus.imem_req_valid, 1'b1);
        chk32("t1_req_addr",  bus.imem_req_addr, 32'h0);
        chk32("t1_next_pc",   bus.next_pc, 32'h4);
        cyc(); bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'h0000_0013;
        cyc();
        #2;
        chk1 ("t1_inst_valid", bus.inst_valid, 1'b1);
        chk32("t1_inst_pc",    bus.inst_pc, 32'h0);
        chk32("t1_inst_data",  bus.inst_data, 32'h13);
        cyc();
        #2 chk32("t1_req2_addr", bus.imem_req_addr, 32'h4);

        // Decode stall for five cycles
        cyc(); bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'hAAAA_0001;
        cyc(); bus.inst_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i != 0) cyc();
            #2;
            chk1 ("t2_inst_valid", bus.inst_valid, 1'b1);
            chk32("t2_inst_pc",    bus.inst_pc, 32'h4);
            chk32("t2_inst_data",  bus.inst_data, 32'hAAAA_0001);
            chk32("t2_next_pc",    bus.next_pc, 32'h8);
            chk1 ("t2_req_valid",  bus.imem_req_valid, 1'b0);
        end
        cyc(); bus.inst_ready = 1'b1;
        cyc();
        #2 chk32("t2_req_addr", bus.imem_req_addr, 32'h8);

        // Redirect while waiting: stale response dropped
        cyc(); bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h40;
        #2 chk32("t3_next_pc", bus.next_pc, 32'h40);
        cyc();
        #2 chk1("t3_flush_req_valid", bus.imem_req_valid, 1'b0);
        cyc(); bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'hDEAD_BEEF;

        // Trap plus redirect on an accepted request
        cyc(); bus.trap = 1'b1; bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h80;
        #2;
        chk1 ("t3_inst_valid", bus.inst_valid, 1'b0);
        chk32("t3_req_addr",   bus.imem_req_addr, 32'h40);
        chk32("t4_next_pc",    bus.next_pc, 32'h100);
        cyc(); bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'h1111_2222;
        #2;
        chk1("t4_misalign", bus.misalign_err, 1'b0);
        chk1("t4_req_valid", bus.imem_req_valid, 1'b0);

        // Misaligned redirect on a withdrawn request
        cyc(); bus.imem_req_ready = 1'b0; bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h42;
        #2;
        chk32("t4_req_addr", bus.imem_req_addr, 32'h100);
        chk32("t5_next_pc",  bus.next_pc, 32'h100);
        cyc(); bus.trap = 1'b1; bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h46;
        #2 chk1("t5_misalign_hi", bus.misalign_err, 1'b1);
        cyc(); bus.redirect_valid = 1'b1; bus.redirect_pc = 32'hFFFF_FFFC;
        #2 chk1("t5_misalign_trap_suppressed", bus.misalign_err, 1'b0);

        // PC wrap, then reset mid-wait
        cyc(); bus.imem_req_ready = 1'b1;
        #2;
        chk32("t6_req_addr", bus.imem_req_addr, 32'hFFFF_FFFC);
        chk32("t6_next_pc",  bus.next_pc, 32'h0);
        cyc(); rst = 1'b1;
        #2;
        chk32("t6_rst_next_pc",   bus.next_pc, C_RESET_PC);
        chk1 ("t6_rst_req_valid", bus.imem_req_valid, 1'b0);
        cyc(); rst = 1'b0;
        #2;
        chk1("t6_inst_valid", bus.inst_valid, 1'b0);
        chk1("t6_idle_req",   bus.imem_req_valid, 1'b0);

        // Response outside WAIT ignored; redirect drops a stalled buffer
        cyc(); bus.imem_req_ready = 1'b0; bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'h77;
        #2 chk32("t7_hold_next_pc", bus.next_pc, 32'h0);
        cyc(); bus.imem_req_ready = 1'b1;
        cyc(); bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'h55;
        cyc(); bus.inst_ready = 1'b0; bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h20;
        #2;
        chk1 ("t7_inst_valid", bus.inst_valid, 1'b1);
        chk32("t7_inst_data",  bus.inst_data, 32'h55);
        cyc(); bus.inst_ready = 1'b1;
        #2;
        chk1 ("t7_dropped",  bus.inst_valid, 1'b0);
        chk32("t7_req_addr", bus.imem_req_addr, 32'h20);
        cyc(); cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
Fetch sequencer wrapped around the PC register. It computes the register's NextPC every cycle and runs the single-outstanding request/response handshake to instruction memory. It presents fetched instructions to decode with valid/ready and applies branch/jump redirects and trap entry. Execution is non-pipelined: one fetch is in flight at a time.

Parameters:
RESET_PC, 32'h00000000, value driven on next_pc during rst; matches the PC register reset value
TRAP_VEC, 32'h00000100, PC loaded on trap or misaligned redirect

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
pc_cur  in  32  current PC (PC register PCOut)
next_pc  out  32  to PC register NextPC
imem_req_valid  out  1  fetch request valid
imem_req_addr  out  32  fetch address (= pc_cur)
imem_req_ready  in  1  imem accepts request
imem_rsp_valid  in  1  response valid, one-cycle pulse
imem_rsp_data  in  32  instruction word
inst_valid  out  1  instruction to decode valid
inst_data  out  32  buffered instruction
inst_pc  out  32  PC of buffered instruction
inst_ready  in  1  decode accepts
redirect_valid  in  1  branch/jump taken, one-cycle pulse
redirect_pc  in  32  redirect target
trap  in  1  trap entry, one-cycle pulse
misalign_err  out  1  registered pulse: redirect target[1:0] != 0

Behaviour:
- States: IDLE, REQ, WAIT, OUT, FLUSH. Reset enters IDLE.
- Reset values: inst_valid=0, inst_data=0, inst_pc=0, misalign_err=0, req_pc=0.
- While rst=1: next_pc=RESET_PC and imem_req_valid=0.
- next_pc priority, combinational:
  - trap -> TRAP_VEC
  - else redirect_valid with redirect_pc[1:0]!=0 -> TRAP_VEC
  - else redirect_valid -> redirect_pc
  - else REQ && imem_req_ready -> pc_cur+4 (mod 2^32; 32'hFFFFFFFC wraps to 0)
  - else pc_cur (hold)
- IDLE: imem_req_valid=0. Always moves to REQ next cycle.
- REQ: imem_req_valid=1, imem_req_addr=pc_cur.
  - On ready: req_pc<=pc_cur, go to WAIT.
  - Without ready: stay, address stable.
- WAIT: on imem_rsp_valid, inst_data<=rsp_data, inst_pc<=req_pc, inst_valid<=1, go to OUT. Latency: rsp in cycle M gives inst_valid=1 in cycle M+1.
- OUT: inst_valid=1, outputs stable.
  - inst_ready=1: inst_valid<=0, go to REQ.
  - inst_ready=0: hold (stall); next_pc=pc_cur.
- Redirect/trap (any state, "flush event"):
  - inst_valid<=0 next cycle.
  - REQ without ready: request withdrawn; go to REQ, new address next cycle. Request withdrawal is permitted only on a flush event.
  - REQ with ready same cycle: the handshake counts as issued, so go to FLUSH. The target overrides +4.
  - WAIT without rsp: go to FLUSH.
  - WAIT with rsp same cycle: response discarded; go to REQ.
  - OUT: buffer dropped regardless of inst_ready; go to REQ.
  - FLUSH: stay in FLUSH (still one outstanding response); next_pc=new target.
  - IDLE: go to REQ; next_pc=target.
- FLUSH: imem_req_valid=0. The next imem_rsp_valid is discarded, never reaching inst_*, then go to REQ.
- misalign_err=1 in the cycle after redirect_valid with target[1:0]!=0 and trap=0. It is suppressed when trap is set the same cycle.
- imem_rsp_valid outside WAIT/FLUSH is ignored.

Test Plan:
1. Reset, then rst=0, ready=1, rsp 1 cycle after accept with 32'h00000013 -> next_pc=0 during rst; request at 0x0; inst_valid with inst_pc=0, inst_data=0x13; next request at 0x4.
2. inst_ready=0 for 5 cycles in OUT -> inst_valid stays 1 with data/pc stable; next_pc=pc_cur; imem_req_valid=0; after inst_ready=1, request at the next PC.
3. redirect_pc=0x40 in WAIT, rsp 2 cycles later -> FLUSH; stale rsp dropped (inst_valid never 1); next request at 0x40.
4. trap and redirect(0x80) in the same cycle as REQ&ready -> next_pc=0x100; FLUSH; next request at 0x100; misalign_err=0.
5. redirect_pc=0x42 -> next_pc=0x100; misalign_err=1 for exactly one cycle.
6. pc_cur=0xFFFFFFFC, request accepted -> next_pc=0x00000000. rst asserted mid-WAIT -> IDLE, inst_valid=0, next_pc=RESET_PC.
